// File: rtl/tb_multi_output_checker.sv
// Multi-channel output checker: compares N DUT channels against delayed expected
// values and keeps per-channel error flags, saturating counts and a first-error capture.
module tb_multi_output_checker #(
  parameter int pCHANNELS = 4,
  parameter int pWIDTH    = 1,
  parameter int pMAX_LAT  = 7,
  parameter int pCOUNT_W  = 16,
  parameter int pTS_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [4:0]                    latency,
  input  logic [pCHANNELS-1:0]          ch_mask,
  input  logic [pCHANNELS*pWIDTH-1:0]   actual,
  input  logic [pCHANNELS*pWIDTH-1:0]   expected,
  input  logic [pCHANNELS-1:0]          exp_valid,
  output logic [pCHANNELS-1:0]          error,
  output logic [pCHANNELS-1:0]          error_sticky,
  output logic                          any_error,
  output logic [pCHANNELS*pCOUNT_W-1:0] error_count,
  output logic [pCOUNT_W-1:0]           check_count,
  output logic [pTS_W-1:0]              first_err_ts,
  output logic [3:0]                    first_err_chan,
  output logic                          first_err_valid
);

  localparam int DW = pCHANNELS * pWIDTH;

  if (pCHANNELS < 1 || pCHANNELS > 16) begin : g_bad_channels
    $error("tb_multi_output_checker: pCHANNELS must be 1..16");
  end
  if (pMAX_LAT < 1 || pMAX_LAT > 31) begin : g_bad_latency
    $error("tb_multi_output_checker: pMAX_LAT must be 1..31");
  end

  logic [4:0]           lat_c;
  logic [4:0]           lat_prev;
  logic                 en_prev;
  logic [4:0]           warm_cnt;
  logic                 trigger;
  logic                 warm;
  logic [DW-1:0]        exp_pipe [pMAX_LAT];
  logic [pCHANNELS-1:0] vld_pipe [pMAX_LAT];
  logic [DW-1:0]        exp_tap;
  logic [pCHANNELS-1:0] vld_tap;
  logic [pCHANNELS-1:0] performed;
  logic [pCHANNELS-1:0] mismatch;
  logic [3:0]           first_idx;
  logic [pCOUNT_W-1:0]  err_cnt [pCHANNELS];
  logic [pTS_W-1:0]     ts;

  assign lat_c = (latency > 5'(pMAX_LAT)) ? 5'(pMAX_LAT) : latency;

  // Delay line: exp_pipe[k] holds the expected vector from k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < pMAX_LAT; k++) begin
        exp_pipe[k] <= '0;
        vld_pipe[k] <= '0;
      end
    end else begin
      exp_pipe[0] <= expected;
      vld_pipe[0] <= exp_valid;
      for (int k = 1; k < pMAX_LAT; k++) begin
        exp_pipe[k] <= exp_pipe[k-1];
        vld_pipe[k] <= vld_pipe[k-1];
      end
    end
  end

  always_comb begin
    exp_tap = expected;
    vld_tap = exp_valid;
    for (int k = 1; k <= pMAX_LAT; k++) begin
      if (lat_c == 5'(k)) begin
        exp_tap = exp_pipe[k-1];
        vld_tap = vld_pipe[k-1];
      end
    end
  end

  // The triggering cycle is the first of the L suppressed cycles.
  assign trigger = (latency != lat_prev) || (enable && !en_prev);
  assign warm    = (trigger && (lat_c != 5'd0)) || (warm_cnt != 5'd0);

  always_ff @(posedge clk) begin
    lat_prev <= latency;
    en_prev  <= enable;
    if (reset || clear) begin
      warm_cnt <= '0;
    end else if (trigger) begin
      warm_cnt <= (lat_c == 5'd0) ? 5'd0 : lat_c - 5'd1;
    end else if (warm_cnt != 5'd0) begin
      warm_cnt <= warm_cnt - 5'd1;
    end
  end

  always_comb begin
    performed = '0;
    mismatch  = '0;
    for (int i = 0; i < pCHANNELS; i++) begin
      performed[i] = enable && !warm && !ch_mask[i] && vld_tap[i];
      mismatch[i]  = performed[i] &&
                     (actual[i*pWIDTH +: pWIDTH] !== exp_tap[i*pWIDTH +: pWIDTH]);
    end
  end

  always_comb begin
    first_idx = '0;
    for (int i = pCHANNELS - 1; i >= 0; i--) begin
      if (mismatch[i]) first_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      error           <= '0;
      error_sticky    <= '0;
      check_count     <= '0;
      ts              <= '0;
      first_err_ts    <= '0;
      first_err_chan  <= '0;
      first_err_valid <= 1'b0;
      for (int i = 0; i < pCHANNELS; i++) err_cnt[i] <= '0;
    end else begin
      if (enable) begin
        error <= mismatch;
        ts    <= ts + 1'b1;
      end
      error_sticky <= error_sticky | mismatch;
      for (int i = 0; i < pCHANNELS; i++) begin
        if (mismatch[i] && (err_cnt[i] != '1)) err_cnt[i] <= err_cnt[i] + 1'b1;
      end
      if ((|performed) && (check_count != '1)) check_count <= check_count + 1'b1;
      if ((|mismatch) && !first_err_valid) begin
        first_err_ts    <= ts;
        first_err_chan  <= first_idx;
        first_err_valid <= 1'b1;
      end
    end
  end

  assign any_error = |error_sticky;

  for (genvar g = 0; g < pCHANNELS; g++) begin : g_cnt_out
    assign error_count[g*pCOUNT_W +: pCOUNT_W] = err_cnt[g];
  end

endmodule

// File: tb/tb_tb_multi_output_checker.sv
// Randomised scoreboard bench for tb_multi_output_checker: a history-based reference
// model predicts every registered output, a monitor compares them each cycle.
module tb_tb_multi_output_checker;

  localparam int CH  = 4;
  localparam int W   = 2;
  localparam int ML  = 7;
  localparam int CW  = 5;
  localparam int TW  = 16;
  localparam int DW  = CH * W;
  localparam int SAT = (1 << CW) - 1;

  logic           clk;
  logic           reset, enable, clear;
  logic [4:0]     latency;
  logic [CH-1:0]  ch_mask, exp_valid;
  logic [DW-1:0]  actual, expected;
  logic [CH-1:0]  error, error_sticky;
  logic           any_error;
  logic [CH*CW-1:0] error_count;
  logic [CW-1:0]  check_count;
  logic [TW-1:0]  first_err_ts;
  logic [3:0]     first_err_chan;
  logic           first_err_valid;

  tb_multi_output_checker #(
    .pCHANNELS(CH), .pWIDTH(W), .pMAX_LAT(ML), .pCOUNT_W(CW), .pTS_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .latency(latency),
    .ch_mask(ch_mask), .actual(actual), .expected(expected), .exp_valid(exp_valid),
    .error(error), .error_sticky(error_sticky), .any_error(any_error),
    .error_count(error_count), .check_count(check_count), .first_err_ts(first_err_ts),
    .first_err_chan(first_err_chan), .first_err_valid(first_err_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    err;
    logic [CH-1:0]    sticky;
    logic             any;
    logic [CH*CW-1:0] cnt;
    logic [CW-1:0]    chk;
    logic [TW-1:0]    fts;
    logic [3:0]       fchan;
    logic             fv;
  } resp_t;

  logic [$bits(resp_t)-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: outputs plus a per-cycle history of expected inputs
  logic [CH-1:0] m_err = '0, m_sticky = '0;
  int            m_cnt [CH];
  int            m_check = 0, m_ts = 0, m_fts = 0, m_fchan = 0;
  logic          m_fv = 1'b0;
  int            cyc = 0, flush_cyc = 0, last_ev = -100, last_l = 0;
  logic [4:0]    prev_lat = '0;
  logic          prev_en = 1'b0;
  logic [DW-1:0] hist_exp [64];
  logic [CH-1:0] hist_vld [64];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // A compare at cycle t uses the inputs of cycle t-L, valid only if sampled after
  // the last reset/clear, and only once L cycles have passed since the last
  // latency change or enable rise.
  task automatic model_step(input logic rst, clr, en, input logic [4:0] lat,
                            input logic [CH-1:0] mask, vld, input logic [DW-1:0] act, expd);
    int lc, src;
    logic [CH-1:0] mis;
    logic any_perf, ok;
    logic [W-1:0] e;
    resp_t r;
    lc = (int'(lat) > ML) ? ML : int'(lat);
    if (rst || clr) begin
      m_err = '0; m_sticky = '0; m_check = 0; m_ts = 0; m_fts = 0; m_fchan = 0; m_fv = 1'b0;
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
      flush_cyc = cyc; last_ev = -100; last_l = 0;
    end else begin
      if (lat != prev_lat || (en && !prev_en)) begin
        last_ev = cyc;
        last_l  = lc;
      end
      mis = '0;
      any_perf = 1'b0;
      src = cyc - lc;
      for (int c = 0; c < CH; c++) begin
        if (lc == 0) begin
          ok = vld[c];
          e  = expd[c*W +: W];
        end else begin
          ok = (src > flush_cyc) && hist_vld[src & 63][c];
          e  = hist_exp[src & 63][c*W +: W];
        end
        if (en && (cyc >= last_ev + last_l) && !mask[c] && ok) begin
          any_perf = 1'b1;
          if (act[c*W +: W] !== e) mis[c] = 1'b1;
        end
      end
      if (en) m_err = mis;
      m_sticky = m_sticky | mis;
      for (int c = 0; c < CH; c++) if (mis[c] && m_cnt[c] < SAT) m_cnt[c]++;
      if (any_perf && m_check < SAT) m_check++;
      if (mis != '0 && !m_fv) begin
        m_fv  = 1'b1;
        m_fts = m_ts;
        for (int c = CH - 1; c >= 0; c--) if (mis[c]) m_fchan = c;
      end
      if (en) m_ts = (m_ts + 1) % (1 << TW);
    end
    hist_exp[cyc & 63] = expd;
    hist_vld[cyc & 63] = vld;
    prev_lat = lat;
    prev_en  = en;
    cyc++;
    r.err = m_err; r.sticky = m_sticky; r.any = |m_sticky;
    for (int c = 0; c < CH; c++) r.cnt[c*CW +: CW] = CW'(m_cnt[c]);
    r.chk = CW'(m_check); r.fts = TW'(m_fts); r.fchan = 4'(m_fchan); r.fv = m_fv;
    exp_q.push_back(r);
  endtask

  // driver tasks
  task automatic drive_cycle(input logic rst, clr, en, input logic [4:0] lat,
                             input logic [CH-1:0] mask, vld, input logic [DW-1:0] act, expd);
    @(negedge clk);
    reset = rst; clear = clr; enable = en; latency = lat;
    ch_mask = mask; exp_valid = vld; actual = act; expected = expd;
    model_step(rst, clr, en, lat, mask, vld, act, expd);
  endtask

  // actual tracks expected delayed by gen_lat; channels in bad (or randomly) are corrupted
  task automatic rand_cycle(input logic rst, clr, en, input logic [4:0] lat, input int gen_lat,
                            input logic [CH-1:0] mask, vld, bad, input int err_pct);
    logic [DW-1:0] e, a;
    int gl;
    e  = DW'($urandom);
    gl = (gen_lat > ML) ? ML : gen_lat;
    a  = (gl == 0) ? e : hist_exp[(cyc - gl) & 63];
    for (int c = 0; c < CH; c++) begin
      if (bad[c] || ($urandom_range(0, 99) < err_pct))
        a[c*W +: W] = a[c*W +: W] ^ W'($urandom_range(1, (1 << W) - 1));
    end
    drive_cycle(rst, clr, en, lat, mask, vld, a, e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // scoreboard monitor
  initial begin
    resp_t r;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        r = resp_t'(exp_q.pop_front());
        check("error", 64'(error), 64'(r.err));
        check("error_sticky", 64'(error_sticky), 64'(r.sticky));
        check("any_error", 64'(any_error), 64'(r.any));
        check("error_count", 64'(error_count), 64'(r.cnt));
        check("check_count", 64'(check_count), 64'(r.chk));
        check("first_err_ts", 64'(first_err_ts), 64'(r.fts));
        check("first_err_chan", 64'(first_err_chan), 64'(r.fchan));
        check("first_err_valid", 64'(first_err_valid), 64'(r.fv));
      end
    end
  end

  initial begin
    logic en_r;
    logic [4:0] lat_r;
    logic [CH-1:0] mask_r;
    reset = 1'b1; clear = 1'b0; enable = 1'b0; latency = '0;
    ch_mask = '0; exp_valid = '0; actual = '0; expected = '0;
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    for (int k = 0; k < 64; k++) begin
      hist_exp[k] = '0;
      hist_vld[k] = '0;
    end

    // reset, then matching data with latency 0
    repeat (3) rand_cycle(1'b1, 1'b0, 1'b1, 5'd0, 0, '0, '1, '0, 0);
    repeat (100) rand_cycle(1'b0, 1'b0, 1'b1, 5'd0, 0, '0, '1, '0, 0);
    settle();
    check("clean_any_error", 64'(any_error), 64'd0);
    check("clean_error_count", 64'(error_count), 64'd0);
    check("clean_check_count_sat", 64'(check_count), 64'(SAT));

    // latency 3 matched, then latency 2 against data still delayed by 3
    repeat (25) rand_cycle(1'b0, 1'b0, 1'b1, 5'd3, 3, '0, '1, '0, 0);
    settle();
    check("lat3_no_error", 64'(any_error), 64'd0);
    repeat (25) rand_cycle(1'b0, 1'b0, 1'b1, 5'd2, 3, '0, '1, '0, 0);
    // clamp: latency 20 behaves as pMAX_LAT
    repeat (20) rand_cycle(1'b0, 1'b1, 1'b1, 5'd20, ML, '0, '1, '0, 0);

    // first-error capture: ch2 at ts 57, ch1+ch3 at ts 80
    repeat (2) rand_cycle(1'b1, 1'b0, 1'b1, 5'd0, 0, '0, '1, '0, 0);
    for (int k = 0; k < 90; k++) begin
      rand_cycle(1'b0, 1'b0, 1'b1, 5'd0, 0, '0, '1,
                 (k == 57) ? 4'b0100 : (k == 80) ? 4'b1010 : 4'b0000, 0);
    end
    settle();
    check("first_ts_57", 64'(first_err_ts), 64'd57);
    check("first_chan_2", 64'(first_err_chan), 64'd2);
    check("first_valid", 64'(first_err_valid), 64'd1);
    check("sticky_1110", 64'(error_sticky), 64'b1110);

    // continuous ch0 mismatch saturates its counter and check_count
    rand_cycle(1'b1, 1'b0, 1'b1, 5'd0, 0, '0, '1, '0, 0);
    repeat (40) rand_cycle(1'b0, 1'b0, 1'b1, 5'd0, 0, '0, '1, 4'b0001, 0);
    settle();
    check("sat_count0", 64'(error_count[0 +: CW]), 64'(SAT));
    check("sat_check", 64'(check_count), 64'(SAT));

    // masked channel and invalid expected both ignore ch1 mismatches
    rand_cycle(1'b1, 1'b0, 1'b1, 5'd0, 0, '0, '1, '0, 0);
    repeat (10) rand_cycle(1'b0, 1'b0, 1'b1, 5'd0, 0, 4'b0010, '1, 4'b0010, 0);
    repeat (10) rand_cycle(1'b0, 1'b0, 1'b1, 5'd0, 0, '0, 4'b1101, 4'b0010, 0);
    settle();
    check("mask_sticky", 64'(error_sticky), 64'd0);
    check("mask_count", 64'(error_count), 64'd0);
    check("mask_checks", 64'(check_count), 64'd20);

    // clear in the same cycle as a mismatch wins
    repeat (2) rand_cycle(1'b0, 1'b0, 1'b1, 5'd0, 0, '0, '1, 4'b0001, 0);
    rand_cycle(1'b0, 1'b1, 1'b1, 5'd0, 0, '0, '1, 4'b0001, 0);
    settle();
    check("clear_fv", 64'(first_err_valid), 64'd0);
    check("clear_sticky", 64'(error_sticky), 64'd0);

    // reset mid-run, then an immediate compare is counted
    repeat (9) rand_cycle(1'b0, 1'b0, 1'b1, 5'd0, 0, '0, '1, 4'b0001, 0);
    settle();
    check("pre_reset_count9", 64'(error_count[0 +: CW]), 64'd9);
    rand_cycle(1'b1, 1'b0, 1'b1, 5'd0, 0, '0, '1, 4'b0001, 0);
    rand_cycle(1'b0, 1'b0, 1'b1, 5'd0, 0, '0, '1, 4'b0001, 0);
    settle();
    check("post_reset_count1", 64'(error_count[0 +: CW]), 64'd1);

    // random mix of latency changes, enable gaps, masks, clears and resets
    en_r = 1'b1; lat_r = 5'd0; mask_r = '0;
    repeat (700) begin
      if ($urandom_range(0, 19) == 0) lat_r = 5'($urandom_range(0, 10));
      if ($urandom_range(0, 29) == 0) en_r = !en_r;
      if ($urandom_range(0, 24) == 0)
        mask_r = ($urandom_range(0, 2) == 0) ? CH'($urandom_range(0, 15)) : '0;
      rand_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0), en_r, lat_r,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'(lat_r),
                 mask_r, CH'($urandom_range(0, 15) | $urandom_range(0, 15)), '0, 8);
    end

    repeat (2) @(posedge clk);
    #4;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
